// File: rtl/mux_arb_8.sv
// Round-robin 8:1 arbitrating multiplexer with a registered, handshaked output word.
// A word is held until downstream accepts it; the pointer rotates only on acceptance.
module mux_arb_8 #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    input  logic [width-1:0] In1,
    input  logic [width-1:0] In2,
    input  logic [width-1:0] In3,
    input  logic [width-1:0] In4,
    input  logic [width-1:0] In5,
    input  logic [width-1:0] In6,
    input  logic [width-1:0] In7,
    input  logic [width-1:0] In8,
    input  logic             out_ready,
    output logic [width-1:0] Mout,
    output logic             out_valid,
    output logic [2:0]       addr,
    output logic [7:0]       grant,
    output logic             busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state, next_state;
    logic [2:0]       ptr;
    logic [2:0]       base_ptr;
    logic [2:0]       winner;
    logic             handshake;
    logic             load;
    logic [width-1:0] sel_data;

    // First asserted request at or after position p, searching upward with wrap.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = p + 3'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    // On acceptance the pointer advance and the new arbitration happen in the same edge.
    always_comb begin
        handshake = (state == HOLD) && out_ready;
        base_ptr  = handshake ? addr + 3'd1 : ptr;
        winner    = pick(req, base_ptr);
        load      = (req != 8'd0) && ((state == IDLE) || handshake);
    end

    always_comb begin
        sel_data = In1;
        case (winner)
            3'd0: sel_data = In1;
            3'd1: sel_data = In2;
            3'd2: sel_data = In3;
            3'd3: sel_data = In4;
            3'd4: sel_data = In5;
            3'd5: sel_data = In6;
            3'd6: sel_data = In7;
            3'd7: sel_data = In8;
            default: sel_data = In1;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (load) next_state = HOLD;
            HOLD: if (handshake && !load) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 3'd0;
            addr      <= 3'd0;
            grant     <= 8'd0;
            Mout      <= '0;
            out_valid <= 1'b0;
        end else begin
            if (handshake) ptr <= addr + 3'd1;
            if (load) begin
                addr      <= winner;
                grant     <= 8'd1 << winner;
                Mout      <= sel_data;
                out_valid <= 1'b1;
            end else if (handshake) begin
                // addr and Mout deliberately keep the last accepted word
                grant     <= 8'd0;
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = out_valid;

endmodule

// File: tb/tb_mux_arb_8.sv
// Directed bench for mux_arb_8: vector table plus hand sequences for fairness,
// backpressure, wrap and asynchronous reset, with per-cycle invariant checks.
module tb_mux_arb_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din [8];
    logic       out_ready;
    logic [7:0] Mout;
    logic       out_valid;
    logic [2:0] addr;
    logic [7:0] grant;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int rst_events = 0;

    always #5 clk = ~clk;

    mux_arb_8 #(.width(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .In1(din[0]), .In2(din[1]), .In3(din[2]), .In4(din[3]),
        .In5(din[4]), .In6(din[5]), .In7(din[6]), .In8(din[7]),
        .out_ready(out_ready), .Mout(Mout), .out_valid(out_valid),
        .addr(addr), .grant(grant), .busy(busy)
    );

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic [7:0] base;
        logic [2:0] addr;
        logic [7:0] grant;
        logic [7:0] mout;
        logic       valid;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < 8; i++) din[i] = base + 8'(i);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [2:0] a, input logic [7:0] g,
                             input logic [7:0] m, input logic v);
        chk({tag, "_addr"}, 32'(addr), 32'(a));
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_mout"}, 32'(Mout), 32'(m));
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_busy"}, 32'(busy), 32'(v));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req = 8'd0;
        out_ready = 1'b0;
        step();
        step();
        check_out("reset", 3'd0, 8'd0, 8'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    // Per-cycle invariants; the Mout stability check is skipped across a reset pulse.
    logic [7:0] prev_mout;
    logic       prev_hold = 1'b0;
    int         prev_rst_events = 0;

    always @(negedge rst_n) rst_events++;

    always @(negedge clk) begin
        checks++;
        if (!$onehot0(grant) || ((grant != 8'd0) != out_valid) || (busy != out_valid)) begin
            errors++;
            $display("FAIL invariant: grant=%0h out_valid=%0b busy=%0b", grant, out_valid, busy);
        end
        if (prev_hold && rst_n && (rst_events == prev_rst_events)) begin
            checks++;
            if (Mout !== prev_mout) begin
                errors++;
                $display("FAIL mout_stable: got %0h expected %0h", Mout, prev_mout);
            end
        end
        prev_mout       = Mout;
        prev_hold       = out_valid && !out_ready && rst_n;
        prev_rst_events = rst_events;
    end

    initial begin
        // req, rdy, base (In k+1 = base + k), expected addr, grant, Mout, out_valid
        vecs[0]  = '{8'h04, 1'b1, 8'hA3, 3'd2, 8'h04, 8'hA5, 1'b1};
        vecs[1]  = '{8'h00, 1'b1, 8'hA3, 3'd2, 8'h00, 8'hA5, 1'b0};
        vecs[2]  = '{8'hFF, 1'b1, 8'h10, 3'd3, 8'h08, 8'h13, 1'b1};
        vecs[3]  = '{8'hFF, 1'b1, 8'h20, 3'd4, 8'h10, 8'h24, 1'b1};
        vecs[4]  = '{8'h01, 1'b0, 8'h30, 3'd4, 8'h10, 8'h24, 1'b1};
        vecs[5]  = '{8'h01, 1'b1, 8'h30, 3'd0, 8'h01, 8'h30, 1'b1};
        vecs[6]  = '{8'h81, 1'b1, 8'h40, 3'd7, 8'h80, 8'h47, 1'b1};
        vecs[7]  = '{8'h81, 1'b1, 8'h50, 3'd0, 8'h01, 8'h50, 1'b1};
        vecs[8]  = '{8'h01, 1'b1, 8'h60, 3'd0, 8'h01, 8'h60, 1'b1};
        vecs[9]  = '{8'h00, 1'b1, 8'h70, 3'd0, 8'h00, 8'h60, 1'b0};
        vecs[10] = '{8'h00, 1'b0, 8'h80, 3'd0, 8'h00, 8'h60, 1'b0};
        vecs[11] = '{8'hC0, 1'b0, 8'h90, 3'd6, 8'h40, 8'h96, 1'b1};
        vecs[12] = '{8'h00, 1'b1, 8'h90, 3'd6, 8'h00, 8'h96, 1'b0};
        vecs[13] = '{8'h81, 1'b1, 8'hA0, 3'd7, 8'h80, 8'hA7, 1'b1};
        vecs[14] = '{8'h81, 1'b1, 8'hB0, 3'd0, 8'h01, 8'hB0, 1'b1};

        rst_n = 1'b0;
        req = 8'd0;
        out_ready = 1'b0;
        set_data(8'h00);
        #2;
        check_out("por", 3'd0, 8'd0, 8'd0, 1'b0);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            req       = vecs[i].req;
            out_ready = vecs[i].rdy;
            set_data(vecs[i].base);
            step();
            check_out($sformatf("v%0d", i), vecs[i].addr, vecs[i].grant, vecs[i].mout, vecs[i].valid);
        end

        // Fairness: all requesting, always ready -> addr walks 0..7 and wraps
        do_reset();
        set_data(8'hC0);
        req = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_out($sformatf("fair%0d", i), 3'(i % 8), 8'd1 << (i % 8), 8'hC0 + 8'(i % 8), 1'b1);
        end

        // Backpressure: word from requester 5 held while its input changes
        do_reset();
        set_data(8'h00);
        din[5] = 8'h3C;
        req = 8'h20;
        out_ready = 1'b0;
        step();
        check_out("bp_grant", 3'd5, 8'h20, 8'h3C, 1'b1);
        din[5] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("bp_hold%0d", i), 3'd5, 8'h20, 8'h3C, 1'b1);
        end
        req = 8'h00;
        out_ready = 1'b1;
        step();
        check_out("bp_done", 3'd5, 8'h00, 8'h3C, 1'b0);

        // Asynchronous reset while holding a word, then arbitration restarts from ptr 0
        do_reset();
        set_data(8'h00);
        din[1] = 8'h5A;
        req = 8'h02;
        out_ready = 1'b0;
        step();
        check_out("rst_hold", 3'd1, 8'h02, 8'h5A, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_async", 3'd0, 8'h00, 8'h00, 1'b0);
        #1;
        rst_n = 1'b1;
        req = 8'h06;
        din[1] = 8'h11;
        din[2] = 8'h22;
        step();
        check_out("rst_after", 3'd1, 8'h02, 8'h11, 1'b1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
